// File: rtl/packet_framer.sv
// packet_framer: frames a continuous AXI-stream into fixed-size packets, tagging m_tlast from packet_size_logic.
// Latency: an accepted word appears on m_tdata/m_tvalid one cycle later; sustains one word per cycle.
// Backpressure: a 1-deep skid absorbs a single output stall; s_tready is low while the skid holds a word.
module packet_framer #(
  parameter int DATA_W    = 32,
  parameter int PKT_CNT_W = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 enable,
  input  logic [2:0]           size_sel_i,
  input  logic [DATA_W-1:0]    s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [DATA_W-1:0]    m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tlast,
  output logic [11:0]          count_o,
  output logic [2:0]           size_sel_o,
  input  logic                 last_count,
  output logic                 busy,
  output logic                 pkt_done,
  output logic [PKT_CNT_W-1:0] pkt_cnt
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state;
  logic [DATA_W-1:0] skid_dat;
  logic              skid_last;
  logic              skid_vld;
  logic              accept;
  logic              out_hs;
  logic              out_free;

  // The skid is only ever filled while the output register is stalled, so
  // "skid occupied" is exactly "two words held" and input must stop.
  assign s_tready = (state == ACTIVE) & ~skid_vld;
  assign accept   = s_tvalid & s_tready;
  assign out_hs   = m_tvalid & m_tready;
  assign out_free = out_hs | ~m_tvalid;
  assign busy     = (state == ACTIVE) | m_tvalid | skid_vld;

  // Framing FSM: word index and size code move only on accept, so last_count is stable per cycle
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      count_o    <= '0;
      size_sel_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            size_sel_o <= size_sel_i;
            count_o    <= '0;
            state      <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (accept) begin
            if (last_count) begin
              count_o <= '0;
              // Packet boundary: either start the next packet with a fresh size or stop
              if (enable) size_sel_o <= size_sel_i;
              else        state      <= IDLE;
            end else begin
              count_o <= count_o + 12'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register plus skid: skid drains first, otherwise a new word loads directly
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tdata   <= '0;
      m_tlast   <= 1'b0;
      m_tvalid  <= 1'b0;
      skid_dat  <= '0;
      skid_last <= 1'b0;
      skid_vld  <= 1'b0;
    end else if (out_free) begin
      if (skid_vld) begin
        m_tdata  <= skid_dat;
        m_tlast  <= skid_last;
        m_tvalid <= 1'b1;
        skid_vld <= 1'b0;
      end else if (accept) begin
        m_tdata  <= s_tdata;
        m_tlast  <= last_count;
        m_tvalid <= 1'b1;
      end else begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end
    end else if (accept) begin
      skid_dat  <= s_tdata;
      skid_last <= last_count;
      skid_vld  <= 1'b1;
    end
  end

  // Completed-packet pulse and wrapping counter, driven by the tlast handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_done <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      pkt_done <= out_hs & m_tlast;
      if (out_hs & m_tlast) pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_packet_framer.sv
// tb_packet_framer: directed stimulus with a transaction-level model and scoreboard for packet_framer.
// The bench also plays the role of packet_size_logic, decoding count_o/size_sel_o into last_count.
// The model tracks words held by the DUT as a queue and derives every output from packet rules.
module tb_packet_framer;

  logic        aclk;
  logic        aresetn;
  logic        enable;
  logic [2:0]  size_sel_i;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [11:0] count_o;
  logic [2:0]  size_sel_o;
  logic        last_count;
  logic        busy;
  logic        pkt_done;
  logic [15:0] pkt_cnt;

  packet_framer #(.DATA_W(32), .PKT_CNT_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .size_sel_i(size_sel_i),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .count_o(count_o), .size_sel_o(size_sel_o), .last_count(last_count),
    .busy(busy), .pkt_done(pkt_done), .pkt_cnt(pkt_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Packet length in words for a size code
  function automatic int sz(input logic [2:0] s);
    return (s == 3'd7) ? 4093 : (32 << s);
  endfunction

  assign last_count = (int'(count_o) == sz(size_sel_o) - 1);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [31:0] d; logic l; } ent_t;
  ent_t        q[$];
  logic        m_act = 1'b0;
  int          m_idx = 0;
  logic [2:0]  m_sel = 3'd0;
  logic [15:0] m_cnt = 16'd0;
  logic        m_pd  = 1'b0;
  int          out_idx = 0;
  int          lastpos[$];

  // Per-cycle compare against the model, then advance the model across the coming edge
  always @(negedge aclk) begin
    if (!aresetn) begin
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pkt_done", pkt_done, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      chk("rst_count_o", count_o, 0);
      chk("rst_size_sel_o", size_sel_o, 0);
      q.delete();
      m_act = 1'b0; m_idx = 0; m_sel = 3'd0; m_cnt = 16'd0; m_pd = 1'b0;
    end else begin
      chk("m_tvalid", m_tvalid, q.size() != 0);
      chk("s_tready", s_tready, m_act && (q.size() < 2));
      chk("busy", busy, m_act || (q.size() != 0));
      chk("count_o", count_o, m_idx);
      chk("size_sel_o", size_sel_o, m_sel);
      chk("pkt_done", pkt_done, m_pd);
      chk("pkt_cnt", pkt_cnt, m_cnt);
      if (m_tvalid && q.size() != 0) begin
        chk("m_tdata", m_tdata, q[0].d);
        chk("m_tlast", m_tlast, q[0].l);
      end
      m_pd = 1'b0;
      if (m_tvalid && m_tready && q.size() != 0) begin
        if (q[0].l) begin
          m_pd = 1'b1;
          m_cnt = m_cnt + 16'd1;
          lastpos.push_back(out_idx);
        end
        out_idx++;
        void'(q.pop_front());
      end
      if (s_tvalid && s_tready) begin
        ent_t e;
        e.d = s_tdata;
        e.l = (m_idx == sz(m_sel) - 1);
        q.push_back(e);
        if (e.l) begin
          m_idx = 0;
          if (enable) m_sel = size_sel_i;
          else        m_act = 1'b0;
        end else begin
          m_idx++;
        end
      end else if (!m_act && enable) begin
        m_act = 1'b1;
        m_sel = size_sel_i;
        m_idx = 0;
      end
    end
  end

  logic [31:0] dctr = 32'h1000_0000;

  // Offer words until n are accepted; enable drops after drop_at accepts, size code changes after sel_at
  task automatic send(input int n, input int vpct, input int rpct,
                      input int drop_at, input int sel_at, input logic [2:0] sel2);
    int acc_n = 0;
    int cyc = 0;
    while (acc_n < n && cyc < n * 10 + 200) begin
      s_tvalid = ($urandom_range(99) < vpct);
      s_tdata  = dctr;
      m_tready = ($urandom_range(99) < rpct);
      @(negedge aclk);
      if (s_tvalid && s_tready) begin
        acc_n++;
        dctr = dctr + 32'd1;
      end
      @(posedge aclk); #1;
      cyc++;
      if (acc_n == drop_at) enable = 1'b0;
      if (acc_n == sel_at) size_sel_i = sel2;
    end
    s_tvalid = 1'b0;
    chk("send_words_accepted", acc_n, n);
  endtask

  task automatic drain();
    int cyc = 0;
    m_tready = 1'b1;
    while (busy && cyc < 100) begin
      @(posedge aclk); #1;
      cyc++;
    end
    chk("drain_busy", busy, 0);
  endtask

  task automatic chk_last(input int n, input int a, input int b);
    chk("lastpos_count", lastpos.size(), n);
    if (lastpos.size() > 0) chk("lastpos_0", lastpos[0], a);
    if (lastpos.size() > 1 && n > 1) chk("lastpos_1", lastpos[1], b);
    lastpos.delete();
    out_idx = 0;
  endtask

  initial begin
    aresetn = 1'b1; enable = 1'b0; size_sel_i = 3'd0;
    s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
    #1 aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_s_tready", s_tready, 0);
    chk("reset_m_tvalid", m_tvalid, 0);
    chk("reset_pkt_cnt", pkt_cnt, 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("idle_s_tready", s_tready, 0);
    chk("idle_busy", busy, 0);

    // Three 32-word packets at full rate
    size_sel_i = 3'd0; enable = 1'b1;
    send(96, 100, 100, 90, -1, 3'd0);
    drain();
    chk_last(3, 31, 63);
    chk("t1_pkt_cnt", pkt_cnt, 3);

    // Enable dropped at word 10: the packet still completes, then idle
    size_sel_i = 3'd0; enable = 1'b1;
    send(32, 100, 100, 10, -1, 3'd0);
    drain();
    chk_last(1, 31, 0);
    chk("t4_s_tready", s_tready, 0);
    chk("t4_pkt_cnt", pkt_cnt, 4);

    // Size code changed mid-packet: 32 words, then 128 words
    size_sel_i = 3'd0; enable = 1'b1;
    send(160, 100, 100, 40, 5, 3'd2);
    drain();
    chk_last(2, 31, 159);
    chk("t5_pkt_cnt", pkt_cnt, 6);

    // 64-word packets under random valid and ready
    size_sel_i = 3'd1; enable = 1'b1;
    send(128, 50, 50, 70, -1, 3'd1);
    drain();
    chk_last(2, 63, 127);
    chk("t3_pkt_cnt", pkt_cnt, 8);

    // Largest code: 4093 words
    size_sel_i = 3'd7; enable = 1'b1;
    send(4093, 100, 100, 100, -1, 3'd7);
    drain();
    chk_last(1, 4092, 0);
    chk("t7_count_o", count_o, 0);
    chk("t7_pkt_cnt", pkt_cnt, 9);

    // Reset at word 20, then a full packet from index 0
    size_sel_i = 3'd0; enable = 1'b1;
    send(20, 100, 100, -1, -1, 3'd0);
    aresetn = 1'b0;
    #1;
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_count_o", count_o, 0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    lastpos.delete();
    out_idx = 0;
    send(32, 100, 100, 5, -1, 3'd0);
    drain();
    chk_last(1, 31, 0);
    chk("t6_pkt_cnt", pkt_cnt, 1);
    chk("t6_count_o", count_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
